// File: rtl/spike_delay_decoder.sv
// Spike delay decoder: timestamps the first rise on each of four spike lines
// relative to a trigger rise and queues (channel, delay) records in a FIFO.
module spike_delay_decoder #(
    parameter int unsigned P_WINDOW     = 5,
    parameter int unsigned P_FIFO_DEPTH = 4,
    localparam int unsigned DW          = $clog2(P_WINDOW + 1)
) (
    input  logic          i_clk,
    input  logic          w_reset_n,
    input  logic [1:0]    i_trigger,
    input  logic [3:0]    i_spike,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [1:0]    o_channel,
    output logic [DW-1:0] o_delay,
    output logic          o_busy,
    output logic          o_done,
    output logic [3:0]    o_missed,
    output logic          o_overflow
);

    localparam int unsigned AW = $clog2(P_FIFO_DEPTH);
    localparam int unsigned RW = 2 + DW;

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } state_t;

    state_t        state_q, state_d;
    logic          trig_q, trig_d;
    logic [3:0]    spike_q, spike_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [3:0]    captured_q, captured_d;
    logic [3:0]    pending_q, pending_d;
    logic [DW-1:0] dly_q [4];
    logic [DW-1:0] dly_d [4];
    logic [RW-1:0] mem_q [P_FIFO_DEPTH];
    logic [RW-1:0] mem_d [P_FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]    missed_q, missed_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;

    logic          trig_rise;
    logic [3:0]    spike_rise;
    logic          armed;
    logic          last;
    logic [3:0]    cap;
    logic [DW-1:0] elapsed;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [1:0]    sel;
    logic [3:0]    clr;

    always_comb begin
        trig_d     = |i_trigger;
        spike_d    = i_spike;
        trig_rise  = trig_d & ~trig_q;
        spike_rise = i_spike & ~spike_q;

        armed   = (state_q == S_ARMED);
        last    = armed && (cnt_q == DW'(P_WINDOW - 1));
        cap     = armed ? (spike_rise & ~captured_q) : '0;
        elapsed = cnt_q + DW'(1);

        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = !empty && i_ready;

        // Lowest-index pending channel wins the single write slot per cycle.
        sel = '0;
        for (int unsigned c = 4; c > 0; c--) begin
            if (pending_q[c-1]) begin
                sel = 2'(c - 1);
            end
        end
        push = (|pending_q) && !full;
        clr  = push ? (4'b0001 << sel) : '0;

        state_d    = state_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        if (!armed) begin
            if (trig_rise) begin
                state_d    = S_ARMED;
                cnt_d      = '0;
                captured_d = '0;
            end
        end else begin
            if (cnt_q < DW'(P_WINDOW)) begin
                cnt_d = cnt_q + DW'(1);
            end
            captured_d = captured_q | cap;
            if (last) begin
                state_d = S_IDLE;
            end
        end

        pending_d = (pending_q & ~clr) | cap;
        for (int unsigned c = 0; c < 4; c++) begin
            dly_d[c] = cap[c] ? elapsed : dly_q[c];
        end

        overflow_d = overflow_q | (|(cap & pending_q));
        missed_d   = last ? ~(captured_q | cap) : missed_q;
        done_d     = last;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {sel, dly_q[sel]};
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge i_clk or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            spike_q    <= '0;
            cnt_q      <= '0;
            captured_q <= '0;
            pending_q  <= '0;
            dly_q      <= '{default: '0};
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            missed_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            spike_q    <= spike_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            pending_q  <= pending_d;
            dly_q      <= dly_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            missed_q   <= missed_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_valid              = !empty;
    assign {o_channel, o_delay} = mem_q[rd_ptr_q[AW-1:0]];
    assign o_busy               = (state_q == S_ARMED);
    assign o_done               = done_q;
    assign o_missed             = missed_q;
    assign o_overflow           = overflow_q;

endmodule

// File: tb/tb_spike_delay_decoder.sv
// Directed bench for spike_delay_decoder: windows driven from per-delay spike
// patterns, records collected by a monitor and compared against hand values.
module tb_spike_delay_decoder;

    localparam int unsigned P_WINDOW = 5;
    localparam int unsigned DW       = 3;

    logic          clk = 1'b0;
    logic          w_reset_n;
    logic [1:0]    i_trigger;
    logic [3:0]    i_spike;
    logic          i_ready;
    logic          o_valid;
    logic [1:0]    o_channel;
    logic [DW-1:0] o_delay;
    logic          o_busy;
    logic          o_done;
    logic [3:0]    o_missed;
    logic          o_overflow;

    spike_delay_decoder #(
        .P_WINDOW    (P_WINDOW),
        .P_FIFO_DEPTH(4)
    ) dut (
        .i_clk     (clk),
        .w_reset_n (w_reset_n),
        .i_trigger (i_trigger),
        .i_spike   (i_spike),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_channel (o_channel),
        .o_delay   (o_delay),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_missed  (o_missed),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  rec_q[$];
    int unsigned stamp_q[$];
    int unsigned k_stamp = 0;

    // Records are taken in the half-cycle before the edge that pops them.
    always @(negedge clk) begin
        if (w_reset_n && o_valid && i_ready) begin
            rec_q.push_back({o_channel, o_delay});
            stamp_q.push_back(cyc_n);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] at(input int d, input logic [3:0] v);
        return {28'd0, v} << (4 * d);
    endfunction

    task automatic check_rec(input string tag, input int idx, input logic [1:0] ch,
                             input logic [2:0] dl, input int rel);
        if (idx < rec_q.size()) begin
            check($sformatf("%s_rec%0d", tag, idx), 32'(rec_q[idx]), 32'({ch, dl}));
            if (rel >= 0) begin
                check($sformatf("%s_lat%0d", tag, idx), stamp_q[idx] - k_stamp, 32'(rel));
            end
        end else begin
            check($sformatf("%s_missing%0d", tag, idx), rec_q.size(), 32'(idx + 1));
        end
    endtask

    // trg bit d / spk nibble d are the values sampled at edge k+d (k = trigger edge).
    task automatic run_window(input string name, input logic [31:0] spk, input logic [7:0] trg);
        i_trigger = '0;
        i_spike   = '0;
        cyc();
        cyc();
        rec_q.delete();
        stamp_q.delete();
        for (int d = 0; d < 8; d++) begin
            i_trigger = trg[d] ? ((d == 0) ? 2'b01 : 2'b10) : 2'b00;
            i_spike   = spk[4*d +: 4];
            cyc();
            if (d == 0) k_stamp = cyc_n;
            check($sformatf("%s_busy_d%0d", name, d), 32'(o_busy), 32'(d < P_WINDOW));
            check($sformatf("%s_done_d%0d", name, d), 32'(o_done), 32'(d == P_WINDOW));
        end
        i_trigger = '0;
        i_spike   = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"},    32'(o_valid),    0);
        check({tag, "_channel"},  32'(o_channel),  0);
        check({tag, "_delay"},    32'(o_delay),    0);
        check({tag, "_busy"},     32'(o_busy),     0);
        check({tag, "_done"},     32'(o_done),     0);
        check({tag, "_missed"},   32'(o_missed),   0);
        check({tag, "_overflow"}, 32'(o_overflow), 0);
    endtask

    initial begin
        w_reset_n = 1'b0;
        i_trigger = '0;
        i_spike   = '0;
        i_ready   = 1'b1;
        repeat (3) cyc();
        check_zero_outputs("reset");
        w_reset_n = 1'b1;
        cyc();

        // Single spike on ch2 at d=3.
        run_window("single", at(3, 4'b0100), 8'b0000_0001);
        repeat (4) cyc();
        check("single_count", rec_q.size(), 1);
        check_rec("single", 0, 2'd2, 3'd3, 4);
        check("single_missed", 32'(o_missed), 32'(4'b1011));

        // Channels 0, 1, 3 together in the last cycle of the window.
        run_window("simul", at(5, 4'b1011), 8'b0000_0001);
        repeat (4) cyc();
        check("simul_count", rec_q.size(), 3);
        check_rec("simul", 0, 2'd0, 3'd5, 6);
        check_rec("simul", 1, 2'd1, 3'd5, 7);
        check_rec("simul", 2, 2'd3, 3'd5, 8);
        check("simul_missed", 32'(o_missed), 32'(4'b0100));

        // Coincident with trigger and one past the window: nothing captured.
        run_window("edge", at(0, 4'b0001) | at(6, 4'b0010), 8'b0000_0001);
        repeat (4) cyc();
        check("edge_count", rec_q.size(), 0);
        check("edge_missed", 32'(o_missed), 32'(4'b1111));

        // d=1 capture, repeated rise on ch1, re-trigger at d=3.
        run_window("misc", at(1, 4'b1000) | at(2, 4'b0010) | at(4, 4'b0010), 8'b0000_1001);
        repeat (4) cyc();
        check("misc_count", rec_q.size(), 2);
        check_rec("misc", 0, 2'd3, 3'd1, 2);
        check_rec("misc", 1, 2'd1, 3'd2, 3);
        check("misc_missed", 32'(o_missed), 32'(4'b0101));
        check("misc_overflow", 32'(o_overflow), 0);

        // Backpressure: FIFO fills, second set waits in pending, third overwrites it.
        i_ready = 1'b0;
        run_window("bpA", at(2, 4'b1111), 8'b0000_0001);
        check("bpA_valid", 32'(o_valid), 1);
        check("bpA_head", 32'({o_channel, o_delay}), 32'({2'd0, 3'd2}));
        check("bpA_missed", 32'(o_missed), 0);
        run_window("bpB", at(4, 4'b1111), 8'b0000_0001);
        check("bpB_overflow", 32'(o_overflow), 0);
        check("bpB_head", 32'({o_channel, o_delay}), 32'({2'd0, 3'd2}));
        run_window("bpC", at(1, 4'b1111), 8'b0000_0001);
        check("bpC_overflow", 32'(o_overflow), 1);
        check("bpC_head", 32'({o_channel, o_delay}), 32'({2'd0, 3'd2}));
        rec_q.delete();
        stamp_q.delete();
        i_ready = 1'b1;
        repeat (12) cyc();
        check("drain_count", rec_q.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check_rec("drainA", i, 2'(i), 3'd2, -1);
            check_rec("drainC", i + 4, 2'(i), 3'd1, -1);
        end
        check("drain_valid", 32'(o_valid), 0);
        check("drain_overflow_sticky", 32'(o_overflow), 1);

        // Reset in the middle of a window with a record waiting.
        i_ready   = 1'b0;
        i_trigger = 2'b01;
        cyc();
        i_trigger = '0;
        i_spike   = 4'b0001;
        cyc();
        i_spike = '0;
        cyc();
        check("pre_rst_valid", 32'(o_valid), 1);
        check("pre_rst_busy", 32'(o_busy), 1);
        w_reset_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        cyc();
        w_reset_n = 1'b1;
        cyc();
        i_ready = 1'b1;
        run_window("post", at(4, 4'b0010), 8'b0000_0001);
        repeat (4) cyc();
        check("post_count", rec_q.size(), 1);
        check_rec("post", 0, 2'd1, 3'd4, 5);
        check("post_missed", 32'(o_missed), 32'(4'b1101));
        check("post_overflow", 32'(o_overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
